rlwe_coeff_add_stream: RTL and testbench
========================================

Name: rlwe_coeff_add_stream

Overview:
- Streaming stage directly downstream of the coefficient modular multiplier in the RLWE datapath.
- Per coefficient it consumes the reduced product a[i]*s[i] mod Q plus an error coefficient e[i], and produces c[i] = (prod + e) mod Q.
- Sequences exactly N coefficients per polynomial, tags each output with its index and last flag, and pulses done after the final output is accepted.
- Valid/ready handshakes on both sides, with a single registered output stage.

Parameters:
- Q, 12289, modulus.
- DATA_WIDTH, 14, coefficient width; requires Q < 2^DATA_WIDTH.
- N, 256, coefficients per polynomial.
- CNT_WIDTH, 9, index counter width; must hold the value N.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one polynomial; honoured only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- in_valid  in  1  upstream has a coefficient pair.
- in_ready  out  1  block accepts the pair this cycle.
- in_prod  in  DATA_WIDTH  reduced product, contract: < Q.
- in_err  in  DATA_WIDTH  error coefficient; unsigned < Q, or signed when SIGNED_ERR_EN is defined.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  (prod + err) mod Q.
- out_idx  out  CNT_WIDTH  coefficient index of out_data, 0..N-1.
- out_last  out  1  high with out_valid when out_idx == N-1.

Behaviour:
- Reset (sync, rst=1 at a clock edge): state=IDLE, in_cnt=0; busy, done, out_valid, out_last = 0; out_data and out_idx = 0.
- Reset overrides everything, including mid-polynomial. Any held output is discarded and no done pulse is produced.
- FSM IDLE:
  - in_ready=0, busy=0.
  - start=1 → RUN, in_cnt cleared to 0.
- FSM RUN:
  - busy=1.
  - Formula: in_ready = (in_cnt < N) && (!out_valid || out_ready).
  - Input handshake = in_valid && in_ready. On handshake the output register loads the result, out_idx<=in_cnt, out_last<=(in_cnt==N-1), out_valid<=1, and in_cnt increments.
  - Output handshake (out_valid && out_ready) with no simultaneous input handshake: out_valid<=0.
  - Simultaneous input and output handshake: the register reloads; out_valid stays 1. This gives full throughput of 1 coefficient/cycle.
  - out_valid=1 && out_ready=0: out_data, out_idx and out_last are held stable; in_ready=0.
  - Handshake on an output with out_last=1 → DONE.
- FSM DONE:
  - done=1 for exactly one cycle, busy=0, then → IDLE.
- start is ignored outside IDLE.
- Latency: 1 cycle from input handshake to out_valid.
- Arithmetic:
  - sum = in_prod + in_err computed at DATA_WIDTH+1 bits.
  - If sum >= Q then result = sum - Q, else result = sum.
  - Single conditional subtract only; inputs outside contract give an unspecified result.
- Boundaries:
  - prod=0, err=0 → 0.
  - sum == Q → 0.
  - N=1: the first output is also last.

Optional Feature:
- Macro: SIGNED_ERR_EN.
- Defined:
  - in_err is two's-complement signed, contract range [-(Q-1)/2, (Q-1)/2].
  - sum is computed signed at DATA_WIDTH+2 bits.
  - If sum < 0, result = sum + Q. Else if sum >= Q, result = sum - Q. Else result = sum.
- Undefined: in_err is unsigned < Q, as in Behaviour.

Test Plan:
- Reset/idle: rst held 3 cycles, then in_valid=1 with no start → out_valid=0, in_ready=0, busy=0 throughout; start=1 → busy=1 next cycle.
- Reduction (N=4, Q=12289): pairs (12000,500), (6000,6289), (0,0), (12288,1) → out_data 211, 0, 0, 0; out_idx 0..3; out_last only on idx 3; done pulses 1 cycle after the last output handshake.
- Backpressure: out_ready=0 for 5 cycles mid-stream → out_data/out_idx stable, in_ready=0; release → no loss or duplication; with in_valid and out_ready held high, 1 output/cycle.
- Mid-op reset: rst asserted after 2 of 4 coefficients → next cycle state IDLE, out_valid=0, no done pulse; a new start processes idx 0..3 correctly.
- Start during RUN: extra start pulse at idx 1 → ignored, count continues to 3, single done.
- SIGNED_ERR_EN: (5,-10) → 12284; (12288,-1) → 12287; (100,6144) → 6244.

Source files
------------

// File: rtl/rlwe_coeff_add_stream.sv
// rlwe_coeff_add_stream: adds an error coefficient to each reduced product,
// reduces mod Q, and streams N tagged results with valid/ready handshakes.
// Optional build macro SIGNED_ERR_EN: treats in_err as two's-complement
// signed and corrects negative sums by adding Q.
module rlwe_coeff_add_stream #(
  parameter int Q          = 12289,
  parameter int DATA_WIDTH = 14,
  parameter int N          = 256,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_prod,
  input  logic [DATA_WIDTH-1:0] in_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_idx,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] N_C    = CNT_WIDTH'(N);
  localparam logic [CNT_WIDTH-1:0] LAST_C = CNT_WIDTH'(N - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_WIDTH-1:0]    in_cnt;
  logic                    in_hs;
  logic                    out_hs;
  logic [DATA_WIDTH-1:0]   result;

`ifdef SIGNED_ERR_EN
  localparam logic signed [DATA_WIDTH+1:0] Q_S = (DATA_WIDTH+2)'(Q);
  logic signed [DATA_WIDTH+1:0] sum_s;
  logic signed [DATA_WIDTH+1:0] adj_s;

  // Signed add with one correction step in either direction
  always_comb begin
    sum_s = $signed({2'b00, in_prod}) + $signed({{2{in_err[DATA_WIDTH-1]}}, in_err});
    adj_s = sum_s;
    if (sum_s[DATA_WIDTH+1]) begin
      adj_s = sum_s + Q_S;
    end else if (sum_s >= Q_S) begin
      adj_s = sum_s - Q_S;
    end
    result = adj_s[DATA_WIDTH-1:0];
  end
`else
  localparam logic [DATA_WIDTH:0] Q_U = (DATA_WIDTH+1)'(Q);
  logic [DATA_WIDTH:0] sum_u;
  logic [DATA_WIDTH:0] adj_u;

  // Unsigned add with a single conditional subtract of Q
  always_comb begin
    sum_u = {1'b0, in_prod} + {1'b0, in_err};
    adj_u = sum_u;
    if (sum_u >= Q_U) begin
      adj_u = sum_u - Q_U;
    end
    result = adj_u[DATA_WIDTH-1:0];
  end
`endif

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Next-state logic plus status and input-ready decoding
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (in_cnt < N_C) && (!out_valid || out_ready);
        if (out_hs && out_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Input coefficient counter, cleared when a polynomial starts
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (state == IDLE && start) begin
      in_cnt <= '0;
    end else if (in_hs) begin
      in_cnt <= in_cnt + 1'b1;
    end
  end

  // Output register: loads on input handshake, empties when drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_idx   <= in_cnt;
      out_last  <= (in_cnt == LAST_C);
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rlwe_coeff_add_stream.sv
// Directed testbench for rlwe_coeff_add_stream with N=4, Q=12289.
module tb_rlwe_coeff_add_stream;

  localparam int DW = 14;
  localparam int CW = 3;
  localparam int NN = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_prod;
  logic [DW-1:0] in_err;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_idx;
  logic          out_last;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] vec_prod [4];
  logic [DW-1:0] vec_err  [4];
  logic [DW-1:0] vec_exp  [4];

  rlwe_coeff_add_stream #(
    .Q(12289), .DATA_WIDTH(DW), .N(NN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_prod = '0; in_err = '0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, done, out_valid, out_last});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== '0 || out_idx !== '0) $display("FAIL reset_data got %0d/%0d want 0/0", out_data, out_idx);
    else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b1; in_prod = 14'd7; in_err = 14'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({out_valid, in_ready, busy} !== 3'b000) $display("FAIL idle_no_start cyc %0d got %b want 000", i, {out_valid, in_ready, busy});
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy);
    else pass_cnt++;
    // Return to IDLE so later tests begin from a clean state
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Runs one full polynomial from IDLE using vec_*; optional extra start at idx start_at
  task automatic run_poly(input string name, input int start_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NN; k++) begin
      in_valid = 1'b1; in_prod = vec_prod[k]; in_err = vec_err[k];
      start = (k == start_at);
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready k=%0d got %b want 1", name, k, in_ready);
      else pass_cnt++;
      tick();
      start = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== vec_exp[k] || out_idx !== CW'(k) || out_last !== (k == NN - 1))
        $display("FAIL %s out k=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                 name, k, out_valid, out_data, out_idx, out_last, vec_exp[k], k, (k == NN - 1));
      else pass_cnt++;
    end
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL %s in_ready_full got %b want 0", name, in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy, out_valid} !== 3'b100) $display("FAIL %s done_pulse got %b want 100", name, {done, busy, out_valid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL %s done_end got %b want 00", name, {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_reduction();
    vec_prod = '{14'd12000, 14'd6000, 14'd0, 14'd12288};
    vec_err  = '{14'd500,   14'd6289, 14'd0, 14'd1};
    vec_exp  = '{14'd211,   14'd0,    14'd0, 14'd0};
    run_poly("reduction", -1);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bp_prod [4];
    logic [DW-1:0] bp_err  [4];
    logic [DW-1:0] bp_exp  [4];
    bp_prod = '{14'd1, 14'd100, 14'd12288, 14'd7000};
    bp_err  = '{14'd2, 14'd200, 14'd12288, 14'd5289};
    bp_exp  = '{14'd3, 14'd300, 14'd12287, 14'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_prod = bp_prod[k]; in_err = bp_err[k];
      tick();
    end
    in_prod = bp_prod[2]; in_err = bp_err[2];
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd1 || out_data !== bp_exp[1])
        $display("FAIL bp_hold c=%0d got r=%b v=%b i=%0d d=%0d want r=0 v=1 i=1 d=%0d",
                 c, in_ready, out_valid, out_idx, out_data, bp_exp[1]);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < NN; k++) begin
      in_valid = 1'b1; in_prod = bp_prod[k]; in_err = bp_err[k];
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_idx !== CW'(k) || out_data !== bp_exp[k])
        $display("FAIL bp_release k=%0d got v=%b i=%0d d=%0d want v=1 i=%0d d=%0d",
                 k, out_valid, out_idx, out_data, k, bp_exp[k]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL bp_done got %b want 1", done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_mid_reset();
    vec_prod = '{14'd10, 14'd20, 14'd30, 14'd12280};
    vec_err  = '{14'd1,  14'd2,  14'd3,  14'd100};
    vec_exp  = '{14'd11, 14'd22, 14'd33, 14'd91};
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_prod = vec_prod[k]; in_err = vec_err[k];
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b000 || out_idx !== '0) $display("FAIL midrst_state got %b idx=%0d want 000 idx=0", {out_valid, busy, done}, out_idx);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL midrst_no_done c=%0d got %b want 0", c, done);
      else pass_cnt++;
    end
    run_poly("midrst_restart", -1);
  endtask

  task automatic test_start_during_run();
    vec_prod = '{14'd6144, 14'd1, 14'd12288, 14'd5};
    vec_err  = '{14'd6145, 14'd1, 14'd0,     14'd12284};
    vec_exp  = '{14'd0,    14'd2, 14'd12288, 14'd0};
    run_poly("start_in_run", 1);
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL start_in_run_idle got %b want 00", {busy, done});
    else pass_cnt++;
  endtask

`ifdef SIGNED_ERR_EN
  task automatic test_signed_err();
    vec_prod = '{14'd5,      14'd12288, 14'd100,  14'd0};
    vec_err  = '{14'h3FF6,   14'h3FFF,  14'd6144, 14'd0};
    vec_exp  = '{14'd12284,  14'd12287, 14'd6244, 14'd0};
    run_poly("signed_err", -1);
  endtask
`endif

  initial begin
    test_reset();
    test_reduction();
    test_backpressure();
    test_mid_reset();
    test_start_during_run();
`ifdef SIGNED_ERR_EN
    test_signed_err();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
